// File: rtl/wave_gen_pkg.sv
// Shared mode encodings and reset-default helpers for the parametrised wave generator.
package wave_gen_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_SQUARE = 3'b000;
    localparam mode_t MODE_TRI    = 3'b001;
    localparam mode_t MODE_SAW_UP = 3'b010;
    localparam mode_t MODE_SAW_DN = 3'b011;

    // Half-scale threshold gives a 50% square wave out of reset.
    function automatic int unsigned default_duty(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/wave_shape.sv
// Combinational waveform shaper: phase index plus active mode/duty to an unattenuated sample.
module wave_shape #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] sample
);
    import wave_gen_pkg::*;

    logic [WIDTH-1:0] tri_v;

    // Doubled phase folds into a symmetric ramp; the top half is mirrored by inversion.
    assign tri_v = {p[WIDTH-2:0], 1'b0};

    always_comb begin
        sample = '0;
        case (sel)
            MODE_SQUARE: sample = (p < duty) ? '1 : '0;
            MODE_TRI:    sample = p[WIDTH-1] ? ~tri_v : tri_v;
            MODE_SAW_UP: sample = p;
            MODE_SAW_DN: sample = ~p;
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/wave_gen_param.sv
// Phase-accumulator function generator with period-aligned config shadowing and wrap strobe.
module wave_gen_param #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     phase_clr,
    input  logic [ACC_W-1:0]         freq_step,
    input  logic [2:0]               sel,
    input  logic [WIDTH-1:0]         duty,
    input  logic [$clog2(WIDTH)-1:0] amp_shift,
    output logic [WIDTH-1:0]         out,
    output logic                     wrap
);
    import wave_gen_pkg::*;

    logic [ACC_W-1:0]         acc;
    logic [ACC_W:0]           sum;
    logic [WIDTH-1:0]         p;
    logic [WIDTH-1:0]         shaped;
    logic [2:0]               sel_a;
    logic [WIDTH-1:0]         duty_a;
    logic [$clog2(WIDTH)-1:0] shift_a;

    assign sum = {1'b0, acc} + {1'b0, freq_step};
    assign p   = acc[ACC_W-1 -: WIDTH];

    wave_shape #(.WIDTH(WIDTH)) u_shape (
        .p      (p),
        .sel    (sel_a),
        .duty   (duty_a),
        .sample (shaped)
    );

    // Config is only taken on a wrap while running, so a period never mixes two shapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            out     <= '0;
            wrap    <= 1'b0;
            sel_a   <= MODE_SQUARE;
            duty_a  <= WIDTH'(default_duty(WIDTH));
            shift_a <= '0;
        end else if (phase_clr) begin
            acc     <= '0;
            out     <= '0;
            wrap    <= 1'b0;
            sel_a   <= sel;
            duty_a  <= duty;
            shift_a <= amp_shift;
        end else if (en) begin
            acc  <= sum[ACC_W-1:0];
            out  <= shaped >> shift_a;
            wrap <= sum[ACC_W];
            if (sum[ACC_W]) begin
                sel_a   <= sel;
                duty_a  <= duty;
                shift_a <= amp_shift;
            end
        end else begin
            wrap    <= 1'b0;
            sel_a   <= sel;
            duty_a  <= duty;
            shift_a <= amp_shift;
        end
    end

endmodule
